// File: rtl/uart_csr_fifo.sv
// -----------------------------------------------------------------------------
// uart_csr_fifo
//
// APB register block for the UART. It holds the UART configuration and control
// bits, a TX byte FIFO that feeds the transmitter over a valid/ready handshake,
// an RX byte FIFO that is filled by the receiver's one-cycle strobe, and an
// optional sticky interrupt block.
//
// Register map (byte addresses; paddr_i[ADDR_W-1:5] must be zero):
//   0x00 TXDATA   W   push pwdata_i[7:0] into the TX FIFO (lane 0 required)
//   0x04 RXDATA   R   pop the RX FIFO head
//   0x08 CFG      RW  [1:0] data bits, [2] stop bits, [3] parity en, [4] type
//   0x0C CTRL     RW  [0] tx_en; [1] TX flush, [2] RX flush (write-1 pulses)
//   0x10 STT      R   FIFO flags [3:0], TX count [15:8], RX count [23:16]
//   0x14 INT_EN   RW  interrupt enables [3:0]         (UART_CSR_IRQ_EN only)
//   0x18 INT_STAT W1C sticky interrupt events [3:0]   (UART_CSR_IRQ_EN only)
//
// Optional feature macro: UART_CSR_IRQ_EN. Without it, 0x14/0x18 are unmapped
// and irq_o is tied low.
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   psel_i, penable_i, pwrite_i        APB control
//   paddr_i, pwdata_i, pstrb_i         APB address, write data, byte lanes
//   prdata_o, pready_o, pslverr_o      APB response (zero wait states)
//   tx_data_o, tx_valid_o, tx_ready_i  TX byte stream toward the transmitter
//   rx_data_i, rx_valid_i, parity_error_i  received byte strobe and flag
//   data_bit_num_o, stop_bit_num_o, parity_en_o, parity_type_o  UART config
//   irq_o                              interrupt request
// -----------------------------------------------------------------------------
module uart_csr_fifo #(
  parameter int ADDR_W   = 12,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  input  logic [3:0]        pstrb_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  input  logic              parity_error_i,
  output logic [1:0]        data_bit_num_o,
  output logic              stop_bit_num_o,
  output logic              parity_en_o,
  output logic              parity_type_o,
  output logic              irq_o
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_CW = RX_AW + 1;

  localparam logic [4:0] ADDR_TXDATA   = 5'h00;
  localparam logic [4:0] ADDR_RXDATA   = 5'h04;
  localparam logic [4:0] ADDR_CFG      = 5'h08;
  localparam logic [4:0] ADDR_CTRL     = 5'h0C;
  localparam logic [4:0] ADDR_STT      = 5'h10;
  localparam logic [4:0] ADDR_INT_EN   = 5'h14;
  localparam logic [4:0] ADDR_INT_STAT = 5'h18;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic acc, apb_wr, apb_rd, addr_hi_ok;
  logic sel_tx, sel_rx, sel_cfg, sel_ctrl;

  assign acc        = psel_i & penable_i;
  assign apb_wr     = acc & pwrite_i;
  assign apb_rd     = acc & ~pwrite_i;
  assign addr_hi_ok = (paddr_i[ADDR_W-1:5] == '0);
  assign sel_tx     = addr_hi_ok & (paddr_i[4:0] == ADDR_TXDATA);
  assign sel_rx     = addr_hi_ok & (paddr_i[4:0] == ADDR_RXDATA);
  assign sel_cfg    = addr_hi_ok & (paddr_i[4:0] == ADDR_CFG);
  assign sel_ctrl   = addr_hi_ok & (paddr_i[4:0] == ADDR_CTRL);

  // Only byte lane 0 carries any writable bits in this map.
  logic ctrl_wr, tx_flush, rx_flush;
  assign ctrl_wr  = apb_wr & sel_ctrl & pstrb_i[0];
  assign tx_flush = ctrl_wr & pwdata_i[1];
  assign rx_flush = ctrl_wr & pwdata_i[2];

  // ---------------------------------------------------------------------------
  // CFG / CTRL registers
  // ---------------------------------------------------------------------------
  logic [4:0] cfg_q;
  logic       tx_en_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q   <= '0;
      tx_en_q <= 1'b0;
    end else begin
      if (apb_wr & sel_cfg & pstrb_i[0]) cfg_q <= pwdata_i[4:0];
      if (ctrl_wr)                       tx_en_q <= pwdata_i[0];
    end
  end

  assign data_bit_num_o = cfg_q[1:0];
  assign stop_bit_num_o = cfg_q[2];
  assign parity_en_o    = cfg_q[3];
  assign parity_type_o  = cfg_q[4];

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [TX_CW-1:0] tx_cnt_q;
  logic             tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty   = (tx_cnt_q == '0);
  assign tx_full    = (tx_cnt_q == TX_CW'(TX_DEPTH));
  // Fullness is judged at the start of the cycle, so a same-cycle pop does
  // not make room for an APB push.
  assign tx_push    = apb_wr & sel_tx & pstrb_i[0] & ~tx_full;
  assign tx_valid_o = tx_en_q & ~tx_empty;
  assign tx_pop     = tx_valid_o & tx_ready_i;
  assign tx_data_o  = tx_empty ? 8'h00 : tx_mem_q[tx_rptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else if (tx_flush) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
    end
  end

  // NOTE: FIFO storage has no reset; the count/pointers define which entries
  // are meaningful, and outputs are masked to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= pwdata_i[7:0];
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [RX_CW-1:0] rx_cnt_q;
  logic             rx_empty, rx_full, rx_push, rx_pop, rx_ovf;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign rx_pop   = apb_rd & sel_rx & ~rx_empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign rx_push  = rx_valid_i & (~rx_full | rx_pop);
  assign rx_ovf   = rx_valid_i & rx_full & ~rx_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else if (rx_flush) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data_i;
  end

  // ---------------------------------------------------------------------------
  // Interrupts
  // ---------------------------------------------------------------------------
`ifdef UART_CSR_IRQ_EN
  logic [3:0] int_en_q, int_stat_q, int_set, int_clr;
  logic       sel_int_en, sel_int_stat;

  assign sel_int_en   = addr_hi_ok & (paddr_i[4:0] == ADDR_INT_EN);
  assign sel_int_stat = addr_hi_ok & (paddr_i[4:0] == ADDR_INT_STAT);

  assign int_set[0] = rx_push & ~rx_flush;
  assign int_set[1] = tx_pop & (tx_cnt_q == TX_CW'(1)) & ~tx_push & ~tx_flush;
  assign int_set[2] = rx_ovf;
  assign int_set[3] = rx_valid_i & parity_error_i;
  assign int_clr    = (apb_wr & sel_int_stat & pstrb_i[0]) ? pwdata_i[3:0] : 4'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_en_q   <= '0;
      int_stat_q <= '0;
    end else begin
      if (apb_wr & sel_int_en & pstrb_i[0]) int_en_q <= pwdata_i[3:0];
      // A new event on the same edge as a write-1-clear keeps the bit set.
      int_stat_q <= (int_stat_q & ~int_clr) | int_set;
    end
  end

  assign irq_o = |(int_stat_q & int_en_q);
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = parity_error_i;
  assign irq_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read data / error mux
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data;
  logic        rd_err;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (!addr_hi_ok) begin
      rd_err = 1'b1;
    end else begin
      case (paddr_i[4:0])
        ADDR_TXDATA: rd_err = pwrite_i & (~pstrb_i[0] | tx_full);
        ADDR_RXDATA: begin
          if (pwrite_i | rx_empty) rd_err  = 1'b1;
          else                     rd_data = {24'h0, rx_mem_q[rx_rptr_q]};
        end
        ADDR_CFG:  rd_data = {27'h0, cfg_q};
        ADDR_CTRL: rd_data = {31'h0, tx_en_q};
        ADDR_STT: begin
          if (pwrite_i) rd_err = 1'b1;
          else rd_data = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q),
                          4'h0, rx_full, rx_empty, tx_full, tx_empty};
        end
`ifdef UART_CSR_IRQ_EN
        ADDR_INT_EN:   rd_data = {28'h0, int_en_q};
        ADDR_INT_STAT: rd_data = {28'h0, int_stat_q};
`endif
        default: rd_err = 1'b1;
      endcase
    end
  end

  assign prdata_o  = apb_rd ? rd_data : 32'h0;
  assign pslverr_o = acc & rd_err;
  assign pready_o  = 1'b1;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{pwdata_i[31:8], pstrb_i[3:1]};

endmodule

// File: tb/tb_uart_csr_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for uart_csr_fifo (default parameters: TX_DEPTH = RX_DEPTH = 8).
// A table of single APB accesses covers the register map after reset; the
// FIFO, simultaneous-event, interrupt and flush behaviour is exercised by
// hand-written sequences. Expected values follow the register map directly.
// -----------------------------------------------------------------------------
module tb_uart_csr_fifo;

  localparam logic [11:0] A_TX   = 12'h000;
  localparam logic [11:0] A_RX   = 12'h004;
  localparam logic [11:0] A_CFG  = 12'h008;
  localparam logic [11:0] A_CTRL = 12'h00C;
  localparam logic [11:0] A_STT  = 12'h010;
  localparam logic [11:0] A_IEN  = 12'h014;
  localparam logic [11:0] A_IST  = 12'h018;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_error;
  logic [1:0]  data_bit_num_o;
  logic        stop_bit_num_o, parity_en_o, parity_type_o, irq_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_csr_fifo #(.ADDR_W(12), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .psel_i         (psel),
    .penable_i      (penable),
    .pwrite_i       (pwrite),
    .paddr_i        (paddr),
    .pwdata_i       (pwdata),
    .pstrb_i        (pstrb),
    .prdata_o       (prdata_o),
    .pready_o       (pready_o),
    .pslverr_o      (pslverr_o),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .parity_error_i (parity_error),
    .data_bit_num_o (data_bit_num_o),
    .stop_bit_num_o (stop_bit_num_o),
    .parity_en_o    (parity_en_o),
    .parity_type_o  (parity_type_o),
    .irq_o          (irq_o)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic wr, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // One APB transfer: setup phase, then access phase during which the RX
  // strobe inputs are also driven. Returns on the falling edge after the
  // completing rising edge, with the bus back to idle.
  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, input logic rxv, input logic [7:0] rxd,
                     input logic rxpe, output logic [31:0] rd, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
    @(negedge clk);
    penable = 1'b1; rx_valid = rxv; rx_data = rxd; parity_error = rxpe;
    #1;
    rd  = prdata_o;
    err = pslverr_o;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    rx_valid = 1'b0; parity_error = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] addr,
                        input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd;
    logic        e;
    apb(1'b0, addr, 32'h0, 4'hF, 1'b0, 8'h00, 1'b0, rd, e);
    check({name, " rdata"}, rd, exp_d);
    check({name, " err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic wr_chk(input string name, input logic [11:0] addr,
                        input logic [31:0] data, input logic exp_e);
    logic [31:0] rd;
    logic        e;
    apb(1'b1, addr, data, 4'hF, 1'b0, 8'h00, 1'b0, rd, e);
    check({name, " err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic pe);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d; parity_error = pe;
    @(negedge clk);
    rx_valid = 1'b0; parity_error = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;

    reset_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; parity_error = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- reset state of outputs ----
    check("rst tx_valid", 32'(tx_valid_o), 32'h0);
    check("rst tx_data", 32'(tx_data_o), 32'h0);
    check("rst irq", 32'(irq_o), 32'h0);
    check("rst pready", 32'(pready_o), 32'h1);
    check("rst cfg outs", 32'({parity_type_o, parity_en_o, stop_bit_num_o, data_bit_num_o}), 32'h0);
    check("idle prdata", prdata_o, 32'h0);
    check("idle pslverr", 32'(pslverr_o), 32'h0);

    // ---- register map table ----
    add_vec("stt reset",      1'b0, A_STT,  32'h0,        4'hF, 32'h0000_0005, 1'b0);
    add_vec("rx empty read",  1'b0, A_RX,   32'h0,        4'hF, 32'h0,         1'b1);
    add_vec("txdata read",    1'b0, A_TX,   32'h0,        4'hF, 32'h0,         1'b0);
    add_vec("stt write",      1'b1, A_STT,  32'hFF,       4'hF, 32'h0,         1'b1);
    add_vec("rxdata write",   1'b1, A_RX,   32'h12,       4'hF, 32'h0,         1'b1);
    add_vec("unmapped read",  1'b0, 12'h01C, 32'h0,       4'hF, 32'h0,         1'b1);
    add_vec("upper addr rd",  1'b0, 12'h108, 32'h0,       4'hF, 32'h0,         1'b1);
    add_vec("unmapped write", 1'b1, 12'h01C, 32'h1,       4'hF, 32'h0,         1'b1);
    add_vec("cfg no lane",    1'b1, A_CFG,  32'h1F,       4'h0, 32'h0,         1'b0);
    add_vec("cfg keep",       1'b0, A_CFG,  32'h0,        4'hF, 32'h0,         1'b0);
    add_vec("cfg write",      1'b1, A_CFG,  32'hFFFF_FFFF, 4'h1, 32'h0,        1'b0);
    add_vec("cfg readback",   1'b0, A_CFG,  32'h0,        4'hF, 32'h1F,        1'b0);
    add_vec("tx no lane",     1'b1, A_TX,   32'h77,       4'h0, 32'h0,         1'b1);
    add_vec("stt tx empty",   1'b0, A_STT,  32'h0,        4'hF, 32'h0000_0005, 1'b0);
    add_vec("ctrl write",     1'b1, A_CTRL, 32'h1,        4'hF, 32'h0,         1'b0);
    add_vec("ctrl readback",  1'b0, A_CTRL, 32'h0,        4'hF, 32'h1,         1'b0);
`ifdef UART_CSR_IRQ_EN
    add_vec("int_en reset",   1'b0, A_IEN,  32'h0,        4'hF, 32'h0,         1'b0);
    add_vec("int_en write",   1'b1, A_IEN,  32'h8,        4'hF, 32'h0,         1'b0);
    add_vec("int_en readback", 1'b0, A_IEN, 32'h0,        4'hF, 32'h8,         1'b0);
`else
    add_vec("int_en unmapped", 1'b0, A_IEN, 32'h0,        4'hF, 32'h0,         1'b1);
    add_vec("int_st unmapped", 1'b1, A_IST, 32'hF,        4'hF, 32'h0,         1'b1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 1'b0, 8'h00, 1'b0, rd, e);
      if (!vecs[i].wr) check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, " err"}, 32'(e), 32'(vecs[i].exp_err));
    end
    #1;
    check("cfg outs", 32'({parity_type_o, parity_en_o, stop_bit_num_o, data_bit_num_o}), 32'h1F);

    // ---- TX path: fill past full, then drain ----
    for (int i = 1; i <= 9; i++) begin
      apb(1'b1, A_TX, 32'hA5, 4'h1, 1'b0, 8'h00, 1'b0, rd, e);
      check($sformatf("tx push %0d err", i), 32'(e), (i == 9) ? 32'h1 : 32'h0);
    end
    #1;
    check("tx valid full", 32'(tx_valid_o), 32'h1);
    check("tx data full", 32'(tx_data_o), 32'hA5);
    rd_chk("stt tx full", A_STT, 32'h0000_0806, 1'b0);

    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("drain %0d valid", i), 32'(tx_valid_o), 32'h1);
      check($sformatf("drain %0d data", i), 32'(tx_data_o), 32'hA5);
      @(negedge clk);
    end
    #1;
    check("drain done valid", 32'(tx_valid_o), 32'h0);
    check("drain done data", 32'(tx_data_o), 32'h0);
    tx_ready = 1'b0;
    rd_chk("stt drained", A_STT, 32'h0000_0005, 1'b0);
`ifdef UART_CSR_IRQ_EN
    rd_chk("int tx empty", A_IST, 32'h2, 1'b0);
    wr_chk("int clr a", A_IST, 32'hF, 1'b0);
`endif

    // ---- RX path: 9 bytes into an 8-deep FIFO ----
    for (int i = 0; i < 9; i++) rx_byte(8'(8'h11 + i), 1'b0);
    rd_chk("stt rx full", A_STT, 32'h0008_0009, 1'b0);
`ifdef UART_CSR_IRQ_EN
    rd_chk("int rx ovf", A_IST, 32'h5, 1'b0);
    wr_chk("int clr b", A_IST, 32'hF, 1'b0);
`endif
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("rx pop %0d", i), A_RX, 32'(8'h11 + i), 1'b0);
    rd_chk("rx pop empty", A_RX, 32'h0, 1'b1);

    // ---- simultaneous pop and push on a full RX FIFO ----
    for (int i = 0; i < 8; i++) rx_byte(8'(8'h21 + i), 1'b0);
    apb(1'b0, A_RX, 32'h0, 4'hF, 1'b1, 8'h55, 1'b0, rd, e);
    check("sim pop rdata", rd, 32'h21);
    check("sim pop err", 32'(e), 32'h0);
    rd_chk("sim stt", A_STT, 32'h0008_0009, 1'b0);
`ifdef UART_CSR_IRQ_EN
    rd_chk("sim no ovf", A_IST, 32'h1, 1'b0);
    wr_chk("int clr c", A_IST, 32'hF, 1'b0);
`endif
    for (int i = 0; i < 7; i++)
      rd_chk($sformatf("sim drain %0d", i), A_RX, 32'(8'h22 + i), 1'b0);
    rd_chk("sim last", A_RX, 32'h55, 1'b0);

    // ---- parity-error interrupt ----
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h66; parity_error = 1'b1;
    #1;
    check("irq before edge", 32'(irq_o), 32'h0);
    @(negedge clk);
    rx_valid = 1'b0; parity_error = 1'b0;
    #1;
`ifdef UART_CSR_IRQ_EN
    check("irq parity", 32'(irq_o), 32'h1);
    apb(1'b1, A_IST, 32'h8, 4'hF, 1'b1, 8'h67, 1'b1, rd, e);
    check("int set beats clr err", 32'(e), 32'h0);
    #1;
    check("irq held", 32'(irq_o), 32'h1);
    rd_chk("int stat held", A_IST, 32'h9, 1'b0);
    wr_chk("int clr parity", A_IST, 32'h8, 1'b0);
    #1;
    check("irq cleared", 32'(irq_o), 32'h0);
`else
    check("irq tied low", 32'(irq_o), 32'h0);
    apb(1'b1, A_IST, 32'h8, 4'hF, 1'b1, 8'h67, 1'b1, rd, e);
    check("int_stat write err", 32'(e), 32'h1);
    #1;
    check("irq still low", 32'(irq_o), 32'h0);
`endif

    // ---- flush ----
    for (int i = 1; i <= 3; i++) wr_chk($sformatf("flush fill %0d", i), A_TX, 32'(i), 1'b0);
    rd_chk("stt pre flush", A_STT, 32'h0002_0300, 1'b0);
    wr_chk("tx flush", A_CTRL, 32'h3, 1'b0);
    #1;
    check("flush tx valid", 32'(tx_valid_o), 32'h0);
    check("flush tx data", 32'(tx_data_o), 32'h0);
    rd_chk("stt post flush", A_STT, 32'h0002_0001, 1'b0);
    rd_chk("ctrl post flush", A_CTRL, 32'h1, 1'b0);
    wr_chk("tx after flush", A_TX, 32'h3C, 1'b0);
    #1;
    check("post flush valid", 32'(tx_valid_o), 32'h1);
    check("post flush data", 32'(tx_data_o), 32'h3C);
    wr_chk("rx flush", A_CTRL, 32'h5, 1'b0);
    rd_chk("stt rx flushed", A_STT, 32'h0000_0104, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
